// File: rtl/decode_pipe_buffer.sv
// Fetch-to-decode pipeline buffer: DEPTH-entry circular queue with valid/ready on both sides.
// Define DECODE_PERF_EN to add the saturating bubble_cnt performance counter.
module decode_pipe_buffer #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]                bubble_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Handshake: a transfer happens on a side exactly in a cycle where valid and
    // ready are both high at the rising edge; ready never depends on valid.
    logic [XLEN-1:0]  r_instr_mem [DEPTH];
    logic [XLEN-1:0]  r_pc_mem    [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;

    assign w_in_ready  = (r_count < CNT_W'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    assign w_head_nxt  = (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + 1'b1;
    assign w_tail_nxt  = (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= w_tail_nxt;
            end
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset; a write during flush is harmless since tail resets.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_tail] <= in_instr;
            r_pc_mem[r_tail]    <= in_pc;
        end
    end

    always_comb begin
        out_instr = NOP_INSTR;
        out_pc    = '0;
        if (w_out_valid) begin
            out_instr = r_instr_mem[r_head];
            out_pc    = r_pc_mem[r_head];
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign occupancy = r_count;

`ifdef DECODE_PERF_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (out_ready && !w_out_valid && !flush && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_decode_pipe_buffer.sv
// Directed bench for decode_pipe_buffer: a DEPTH=2 instance for handshake/flush/reset cases
// and a DEPTH=3 instance for pointer wrap (plus bubble_cnt when DECODE_PERF_EN is defined).
module tb_decode_pipe_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0] in_instr2, in_pc2, out_instr2, out_pc2;
  logic [1:0]  occ2;
  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [31:0] in_instr3, in_pc3, out_instr3, out_pc3;
  logic [1:0]  occ3;
`ifdef DECODE_PERF_EN
  logic [31:0] bubble2, bubble3;
`endif

  decode_pipe_buffer #(.XLEN(32), .DEPTH(2), .NOP_INSTR(NOP)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_instr(in_instr2), .in_pc(in_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2), .out_pc(out_pc2),
    .occupancy(occ2)
`ifdef DECODE_PERF_EN
    , .bubble_cnt(bubble2)
`endif
  );

  decode_pipe_buffer #(.XLEN(32), .DEPTH(3), .NOP_INSTR(NOP)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_instr(in_instr3), .in_pc(in_pc3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_instr(out_instr3), .out_pc(out_pc3),
    .occupancy(occ3)
`ifdef DECODE_PERF_EN
    , .bubble_cnt(bubble3)
`endif
  );

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic rdy);
    in_valid2  = v;
    in_instr2  = instr;
    in_pc2     = pc;
    out_ready2 = rdy;
  endtask

  initial begin
    int pushed, popped, cyc, mcount;
    int exp_bubble;
    logic do_push, do_pop;

    flush = 1'b0;
    drive2(1'b0, 32'h0, 32'h0, 1'b0);
    in_valid3 = 1'b0; in_instr3 = '0; in_pc3 = '0; out_ready3 = 1'b0;

    // reset state
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid2}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready2},  32'd1);
    check("rst_out_instr", out_instr2, NOP);
    check("rst_out_pc",    out_pc2,    32'd0);
    check("rst_occ",       {30'b0, occ2}, 32'd0);

    // reset mid-stream
    drive2(1'b1, 32'h00100093, 32'h0, 1'b0);
    step();
    check("mid_occ1",  {30'b0, occ2}, 32'd1);
    check("mid_instr", out_instr2, 32'h00100093);
    drive2(1'b1, 32'h00200113, 32'h4, 1'b0);
    step();
    check("mid_occ2",   {30'b0, occ2}, 32'd2);
    drive2(1'b0, 32'h0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, out_valid2}, 32'd0);
    check("arst_out_instr", out_instr2, NOP);
    check("arst_out_pc",    out_pc2,    32'd0);
    check("arst_occ",       {30'b0, occ2}, 32'd0);
    check("arst_in_ready",  {31'b0, in_ready2}, 32'd1);
    step();
    rst = 1'b0;

    // fill and stall
    drive2(1'b1, 32'h00A00513, 32'h0, 1'b0);
    step();
    drive2(1'b1, 32'h00B00593, 32'h4, 1'b0);
    step();
    check("fill_occ",      {30'b0, occ2}, 32'd2);
    check("fill_in_ready", {31'b0, in_ready2}, 32'd0);
    drive2(1'b1, 32'h00C00613, 32'h8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_instr", out_instr2, 32'h00A00513);
      check("stall_pc",    out_pc2,    32'h0);
      check("stall_occ",   {30'b0, occ2}, 32'd2);
    end

    // simultaneous push and pop at full: pop happens, push refused
    drive2(1'b1, 32'h00C00613, 32'h8, 1'b1);
    check("full_in_ready", {31'b0, in_ready2}, 32'd0);
    step();
    check("full_pop_occ", {30'b0, occ2}, 32'd1);
    check("full_pop_pc",  out_pc2, 32'h4);
    check("full_pop_ins", out_instr2, 32'h00B00593);
    drive2(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check("drain_valid", {31'b0, out_valid2}, 32'd0);
    check("drain_instr", out_instr2, NOP);

    // streaming: each entry appears one cycle after push, occupancy stays 1
    for (int i = 0; i < 4; i++) begin
      drive2(1'b1, 32'h00000093 | (32'(i + 1) << 20), 32'(i * 4), 1'b1);
      step();
      check("stream_pc",    out_pc2, 32'(i * 4));
      check("stream_instr", out_instr2, 32'h00000093 | (32'(i + 1) << 20));
      check("stream_occ",   {30'b0, occ2}, 32'd1);
    end
    drive2(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check("stream_end_occ", {30'b0, occ2}, 32'd0);

    // flush with push: 0x20 entry must never appear
    drive2(1'b1, 32'h00D00693, 32'h10, 1'b0);
    step();
    check("pre_flush_occ", {30'b0, occ2}, 32'd1);
    flush = 1'b1;
    drive2(1'b1, 32'h00E00713, 32'h20, 1'b0);
    step();
    flush = 1'b0;
    drive2(1'b0, 32'h0, 32'h0, 1'b1);
    check("flush_occ",      {30'b0, occ2}, 32'd0);
    check("flush_valid",    {31'b0, out_valid2}, 32'd0);
    check("flush_instr",    out_instr2, NOP);
    check("flush_in_ready", {31'b0, in_ready2}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("flush_no_ghost", {31'b0, out_valid2}, 32'd0);
    end
    drive2(1'b0, 32'h0, 32'h0, 1'b0);

    // pointer wrap on DEPTH=3 with out_ready toggling every cycle
    pushed = 0; popped = 0; mcount = 0; exp_bubble = 0; cyc = 0;
    while ((pushed < 10 || mcount != 0) && cyc < 100) begin
      out_ready3 = cyc[0];
      in_valid3  = (pushed < 10);
      in_pc3     = 32'(pushed * 4);
      in_instr3  = 32'(pushed * 4) ^ 32'hA5A50000;
      check("wrap_in_ready",  {31'b0, in_ready3},  {31'b0, mcount < 3});
      check("wrap_out_valid", {31'b0, out_valid3}, {31'b0, mcount != 0});
      do_push = in_valid3 && (mcount < 3);
      do_pop  = out_ready3 && (mcount != 0);
      if (out_ready3 && mcount == 0) exp_bubble++;
      if (do_pop) begin
        check("wrap_pc",    out_pc3,    exp_q[0]);
        check("wrap_instr", out_instr3, exp_q[0] ^ 32'hA5A50000);
        void'(exp_q.pop_front());
        popped++;
        mcount--;
      end
      if (do_push) begin
        exp_q.push_back(in_pc3);
        pushed++;
        mcount++;
      end
      step();
      check("wrap_occ", {30'b0, occ3}, 32'(mcount));
      cyc++;
    end
    check("wrap_done", 32'(popped), 32'd10);
    in_valid3 = 1'b0;
`ifdef DECODE_PERF_EN
    out_ready3 = 1'b0;
    #1;
    check("wrap_bubble_cnt", bubble3, 32'(exp_bubble));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_pipe_buffer.md
# decode_pipe_buffer

Parametrised fetch-to-decode pipeline buffer for the RV32i pipeline. It holds up to DEPTH fetched instruction/PC pairs between fetch and decode. A valid/ready handshake on both sides replaces the single enable/stall register. A synchronous flush squashes all held entries on branch redirect. When empty it presents a NOP bubble to decode.

## Interface
- XLEN, 32: instruction and PC width.
- DEPTH, 2: number of buffered entries, ≥1, any integer (not restricted to powers of two).
- NOP_INSTR, 32'h00000013: value driven on out_instr when empty (ADDI x0,x0,0).
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all entries (branch/jump redirect).
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_instr  in  XLEN  fetched instruction.
- in_pc  in  XLEN  PC of the fetched instruction.
- out_valid  out  1  head entry valid toward decode.
- out_ready  in  1  decode accepts head entry (deasserted on decode stall).
- out_instr  out  XLEN  head instruction, or NOP_INSTR when empty.
- out_pc  out  XLEN  head PC, or 0 when empty.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Storage: DEPTH-entry circular buffer with head pointer, tail pointer and count.
- Pointers wrap from DEPTH-1 to 0.
- push = in_valid & in_ready.
  - Writes {in_instr, in_pc} at tail.
  - Advances tail.
- pop = out_valid & out_ready.
  - Advances head.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- in_ready = (count < DEPTH). It depends only on registered state; there is no combinational path from out_ready to in_ready.
  - When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0).
- out_instr and out_pc are driven from the head entry when out_valid is high.
  - When empty they are NOP_INSTR and 0.
- Once out_valid is high, out_instr and out_pc stay stable until pop or flush.
- Flush:
  - Clears count, head and tail to 0 at the next edge.
  - Flush wins over a push or pop in the same cycle. The pushed entry is discarded; fetch must treat it as lost.
  - in_ready and out_valid are not gated by flush in the flush cycle. The handshake may complete, but the entry is dropped.
- Reset (asynchronous, any time, including mid-push/pop) forces:
  - count=0, head=0, tail=0.
  - out_valid=0, in_ready=1.
  - out_instr=NOP_INSTR, out_pc=0, occupancy=0.
- Entry storage contents need not be reset.

## Timing
- Latency: an entry pushed at edge N is visible on out_valid/out_instr after edge N (first-cycle availability).
- There is no bypass from in_* to out_* in the same cycle.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- DEPTH=1 degenerates to a half-rate register under continuous stall release:
  - in_ready is low while full.
  - Push and pop alternate.
- DEPTH≥2 gives full throughput with registered in_ready.
- occupancy updates at the same edge as count.
- Flush asserted at edge N: out_valid=0 after edge N, and in_ready=1 after edge N.

## Configuration
- DECODE_PERF_EN defined:
  - Adds output bubble_cnt (32 bits).
  - Increments each cycle with out_ready=1 and out_valid=0 and flush=0.
  - Saturates at 32'hFFFFFFFF.
  - Reset value 0. Not cleared by flush.
- DECODE_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset mid-stream:
  - Stimulus: fill 2 entries, then assert rst asynchronously between edges.
  - Required response: out_valid=0, out_instr=32'h00000013, out_pc=0, occupancy=0 immediately; in_ready=1.
- Fill and stall (DEPTH=2):
  - Stimulus: push PC 0x0 and 0x4 with out_ready=0.
  - Required response: occupancy=2, in_ready=0; out_instr holds the first instruction with out_pc=0x0 stable for 5 stall cycles. A third in_valid is not accepted.
- Streaming:
  - Stimulus: out_ready=1, push PCs 0x0, 0x4, 0x8, 0xC back-to-back.
  - Required response: each appears in order one cycle after its push; occupancy stays 1; no drops.
- Simultaneous push and pop at full:
  - Stimulus: count=2, in_valid=1, out_ready=1.
  - Required response: pop occurs, push refused (in_ready=0), occupancy=1 next cycle.
- Flush with push:
  - Stimulus: count=1, assert flush together with in_valid=1 at PC 0x20.
  - Required response: next cycle occupancy=0, out_valid=0, out_instr=NOP_INSTR; the 0x20 entry never appears.
- Pointer wrap (DEPTH=3):
  - Stimulus: 10 pushes with out_ready toggling every cycle.
  - Required response: output order matches input order across wrap.
  - With DECODE_PERF_EN defined: bubble_cnt equals the number of cycles with out_ready=1 and empty.
